// File: rtl/ifu_fetch_if.sv
// Fetch-unit bundle: SRAM request/response, decode valid/ready and execute redirect.
// The master modport is the fetch unit's view; slave is the SRAM/decode/execute side.
interface ifu_fetch_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output mem_req, mem_addr, inst_valid, inst, inst_pc,
        input  mem_ready, mem_data, inst_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  mem_req, mem_addr, inst_valid, inst, inst_pc,
        output mem_ready, mem_data, inst_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues one-cycle SRAM requests and hands
// fetched words to decode; redirects restart fetch and drop any stale response.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic          clk,
    input  logic          rst,
    ifu_fetch_if.master   bus
);
    typedef enum logic [1:0] {
        S_BOOT,
        S_REQ,
        S_WAIT,
        S_VALID
    } state_t;

    state_t      r_state, w_state;
    logic [31:0] r_pc, w_pc;
    logic        r_drop, w_drop;
    logic [31:0] r_inst, w_inst;
    logic [31:0] r_inst_pc, w_inst_pc;

    logic [31:0] w_redirect_target;
    logic        w_unused_redirect_lsbs;

    assign w_redirect_target      = {bus.redirect_pc[31:2], 2'b00};
    assign w_unused_redirect_lsbs = ^bus.redirect_pc[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_BOOT;
            r_pc      <= RESET_PC;
            r_drop    <= 1'b0;
            r_inst    <= '0;
            r_inst_pc <= RESET_PC;
        end else begin
            r_state   <= w_state;
            r_pc      <= w_pc;
            r_drop    <= w_drop;
            r_inst    <= w_inst;
            r_inst_pc <= w_inst_pc;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_pc      = r_pc;
        w_drop    = r_drop;
        w_inst    = r_inst;
        w_inst_pc = r_inst_pc;
        if (bus.redirect_valid) begin
            // A request issued this cycle or still outstanding must be awaited and discarded.
            w_pc = w_redirect_target;
            unique case (r_state)
                S_BOOT:  w_state = S_REQ;
                S_REQ: begin
                    w_drop  = 1'b1;
                    w_state = S_WAIT;
                end
                S_WAIT: begin
                    if (bus.mem_ready) begin
                        w_drop  = 1'b0;
                        w_state = S_REQ;
                    end else begin
                        w_drop  = 1'b1;
                    end
                end
                S_VALID: w_state = S_REQ;
                default: w_state = S_BOOT;
            endcase
        end else begin
            unique case (r_state)
                S_BOOT:  w_state = S_REQ;
                S_REQ:   w_state = S_WAIT;
                S_WAIT: begin
                    if (bus.mem_ready) begin
                        if (r_drop) begin
                            w_drop  = 1'b0;
                            w_state = S_REQ;
                        end else begin
                            w_inst    = bus.mem_data;
                            w_inst_pc = r_pc;
                            w_state   = S_VALID;
                        end
                    end
                end
                S_VALID: begin
                    if (bus.inst_ready) begin
                        w_pc    = r_pc + 32'd4;
                        w_state = S_REQ;
                    end
                end
                default: w_state = S_BOOT;
            endcase
        end
    end

    assign bus.mem_req    = (r_state == S_REQ);
    assign bus.mem_addr   = r_pc;
    assign bus.inst_valid = (r_state == S_VALID);
    assign bus.inst       = r_inst;
    assign bus.inst_pc    = r_inst_pc;
endmodule
